// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage in front of a combinational instruction memory.
//   Owns the PC, drives the memory byte address, captures the returned word
//   in the same cycle and buffers {pc, instruction, fault} in a 2-entry FIFO
//   toward decode with a valid/ready handshake. Redirects flush the FIFO and
//   reload the PC; fetches outside the memory window produce a fault entry
//   and halt fetching until the next redirect.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   imem_address     byte address to instruction memory (= pc)
//   imem_instruction combinational word returned for imem_address
//   redirect_valid   branch/jump redirect request (highest priority)
//   redirect_target  new pc on redirect
//   out_valid        FIFO head valid
//   out_ready        decode accepts head this cycle
//   out_instruction  head instruction (0 for faults or when empty)
//   out_pc           head pc (0 when empty)
//   out_fault        head is a fetch fault (0 when empty)
module fetch_stage #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = 32'h1000,
  parameter logic [ADDRESS_SIZE-1:0] MEM_SIZE = 32'h1000
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDRESS_SIZE-1:0] imem_address,
  input  logic [ADDRESS_SIZE-1:0] imem_instruction,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_SIZE-1:0] redirect_target,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_SIZE-1:0] out_instruction,
  output logic [ADDRESS_SIZE-1:0] out_pc,
  output logic                    out_fault
);

  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDRESS = BOOT_ADDRESS + MEM_SIZE - ADDRESS_SIZE'(4);

  logic [ADDRESS_SIZE-1:0] pc;
  logic                    halted;
  logic [1:0]              count;

  // entry 0 is the head, entry 1 the second slot
  logic [ADDRESS_SIZE-1:0] q_pc    [2];
  logic [ADDRESS_SIZE-1:0] q_instr [2];
  logic                    q_fault [2];

  logic                    fault_now;
  logic                    pop;
  logic                    push;
  logic [ADDRESS_SIZE-1:0] new_instr;

  assign imem_address = pc;
  assign fault_now    = (pc < BOOT_ADDRESS) || (pc > LAST_ADDRESS) || (pc[1:0] != 2'b00);
  assign new_instr    = fault_now ? '0 : imem_instruction;

  assign out_valid       = (count != 2'd0);
  assign out_instruction = out_valid ? q_instr[0] : '0;
  assign out_pc          = out_valid ? q_pc[0]    : '0;
  assign out_fault       = out_valid & q_fault[0];

  assign pop  = out_valid & out_ready;
  assign push = !redirect_valid & !halted & ((count < 2'd2) | pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= BOOT_ADDRESS;
      halted  <= 1'b0;
      count   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
        q_fault[i] <= 1'b0;
      end
    end else if (redirect_valid) begin
      pc     <= redirect_target;
      halted <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        // a faulting fetch parks the pc on the offending address
        if (fault_now) begin
          halted <= 1'b1;
        end else begin
          pc <= pc + ADDRESS_SIZE'(4);
        end
      end

      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            q_pc[0] <= pc; q_instr[0] <= new_instr; q_fault[0] <= fault_now;
          end else begin
            q_pc[1] <= pc; q_instr[1] <= new_instr; q_fault[1] <= fault_now;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          q_pc[0] <= q_pc[1]; q_instr[0] <= q_instr[1]; q_fault[0] <= q_fault[1];
          count   <= count - 2'd1;
        end
        2'b11: begin
          // count unchanged; new word lands behind whatever remains
          if (count == 2'd1) begin
            q_pc[0] <= pc; q_instr[0] <= new_instr; q_fault[0] <= fault_now;
          end else begin
            q_pc[0] <= q_pc[1]; q_instr[0] <= q_instr[1]; q_fault[0] <= q_fault[1];
            q_pc[1] <= pc;      q_instr[1] <= new_instr;  q_fault[1] <= fault_now;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // memory model: two fixed words at boot, a recognisable pattern elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000) return 32'h11111111;
    if (a == 32'h1004) return 32'h22222222;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_instruction = mem_word(imem_address);

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .out_fault        (out_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic flt);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instruction, ins);
    check({tag, "_fault"}, {31'd0, out_fault}, {31'd0, flt});
  endtask

  task automatic empty(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_pc"}, out_pc, 32'd0);
    check({tag, "_instr"}, out_instruction, 32'd0);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0; out_ready = 1'b1;
    @(negedge clk);

    // reset state
    empty("rst");
    check("rst_fault", {31'd0, out_fault}, 32'd0);
    check("rst_addr", imem_address, 32'h1000);

    // streaming with out_ready=1
    reset = 1'b1;
    tick();
    head("s0", 32'h1000, 32'h11111111, 1'b0);
    check("s0_addr", imem_address, 32'h1004);
    tick();
    head("s1", 32'h1004, 32'h22222222, 1'b0);
    check("s1_addr", imem_address, 32'h1008);
    tick();
    head("s2", 32'h1008, 32'h1008EFF7, 1'b0);

    // backpressure fills the FIFO, then drains without gaps
    out_ready = 1'b0;
    do_reset();
    tick();
    head("bp0", 32'h1000, 32'h11111111, 1'b0);
    tick();
    tick();
    head("bp_hold", 32'h1000, 32'h11111111, 1'b0);
    check("bp_addr", imem_address, 32'h1008);
    out_ready = 1'b1;
    check("bp_d0", out_pc, 32'h1000);
    tick();
    head("bp_d1", 32'h1004, 32'h22222222, 1'b0);
    tick();
    head("bp_d2", 32'h1008, 32'h1008EFF7, 1'b0);

    // redirect flushes two buffered entries
    out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    check("rd_full", out_pc, 32'h1000);
    redirect_valid = 1'b1; redirect_target = 32'h1800;
    tick();
    redirect_valid = 1'b0;
    empty("rd_gap");
    check("rd_addr", imem_address, 32'h1800);
    tick();
    head("rd_t0", 32'h1800, 32'h1800E7FF, 1'b0);
    out_ready = 1'b1;
    tick();
    head("rd_t1", 32'h1804, 32'h1804E7FB, 1'b0);

    // end of window: 0x1FFC normal, 0x2000 faults and halts
    redirect_valid = 1'b1; redirect_target = 32'h1FF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    head("w0", 32'h1FF8, 32'h1FF8E007, 1'b0);
    tick();
    head("w1", 32'h1FFC, 32'h1FFCE003, 1'b0);
    tick();
    head("w_flt", 32'h2000, 32'h0, 1'b1);
    check("w_flt_addr", imem_address, 32'h2000);
    tick();
    empty("w_halt0");
    check("w_halt_addr", imem_address, 32'h2000);
    tick();
    empty("w_halt1");
    redirect_valid = 1'b1; redirect_target = 32'h1000;
    tick();
    redirect_valid = 1'b0;
    empty("w_rgap");
    tick();
    head("w_resume", 32'h1000, 32'h11111111, 1'b0);

    // misaligned redirect target
    redirect_valid = 1'b1; redirect_target = 32'h1002;
    tick();
    redirect_valid = 1'b0;
    check("mis_addr", imem_address, 32'h1002);
    tick();
    head("mis", 32'h1002, 32'h0, 1'b1);
    tick();
    empty("mis_halt");
    check("mis_halt_addr", imem_address, 32'h1002);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    check("ar_full", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar_async_valid", {31'd0, out_valid}, 32'd0);
    check("ar_async_addr", imem_address, 32'h1000);
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    tick();
    head("ar_restart", 32'h1000, 32'h11111111, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
